fetch_unit: RTL and testbench

- Instruction-fetch stage of the RV32I pipeline, directly upstream of the IF/ID pipeline register.
- Owns the architectural fetch PC and drives the instruction-memory/I-cache request port.
- Presents fetched instructions, with their PCs, to IF/ID over a valid/ready handshake; ready is IF/ID's load.
- Absorbs control-flow redirects from the EX-stage branch/jump resolution, including redirects that arrive while a memory request is outstanding.

---
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request port, EX redirect input and the
// valid/ready hand-off to the IF/ID register. The fetch unit is the master side.
interface fetch_unit_if;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_ir;
    logic [31:0] out_pc;

    modport master (
        output imem_read, imem_address, out_valid, out_ir, out_pc,
        input  imem_rdata, imem_resp, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_read, imem_address, out_valid, out_ir, out_pc,
        output imem_rdata, imem_resp, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: owns the fetch PC, keeps one imem read outstanding and
// hands instructions to IF/ID through a registered output slot backed by a skid slot.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h6000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {REQ, HOLD, DROP} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] req_addr_reg, req_addr_next;
    logic        out_valid_reg, out_valid_next;
    logic [31:0] out_ir_reg, out_ir_next;
    logic [31:0] out_pc_reg, out_pc_next;
    logic        skid_valid_reg, skid_valid_next;
    logic [31:0] skid_ir_reg, skid_ir_next;
    logic [31:0] skid_pc_reg, skid_pc_next;
    logic        slot_free;

    assign slot_free = !out_valid_reg || bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= REQ;
            pc_reg         <= RESET_PC;
            req_addr_reg   <= RESET_PC;
            out_valid_reg  <= 1'b0;
            out_ir_reg     <= NOP_INSTR;
            out_pc_reg     <= 32'h0;
            skid_valid_reg <= 1'b0;
            skid_ir_reg    <= NOP_INSTR;
            skid_pc_reg    <= 32'h0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            req_addr_reg   <= req_addr_next;
            out_valid_reg  <= out_valid_next;
            out_ir_reg     <= out_ir_next;
            out_pc_reg     <= out_pc_next;
            skid_valid_reg <= skid_valid_next;
            skid_ir_reg    <= skid_ir_next;
            skid_pc_reg    <= skid_pc_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        req_addr_next   = req_addr_reg;
        out_valid_next  = out_valid_reg;
        out_ir_next     = out_ir_reg;
        out_pc_next     = out_pc_reg;
        skid_valid_next = skid_valid_reg;
        skid_ir_next    = skid_ir_reg;
        skid_pc_next    = skid_pc_reg;

        if (bus.redirect_valid) begin
            pc_next         = bus.redirect_pc & ~32'd3;
            out_valid_next  = 1'b0;
            out_ir_next     = NOP_INSTR;
            skid_valid_next = 1'b0;
            case (state_reg)
                REQ: begin
                    // The in-flight read must still complete; remember its address for DROP.
                    if (!bus.imem_resp) begin
                        state_next    = DROP;
                        req_addr_next = pc_reg & ~32'd3;
                    end
                end
                HOLD:    state_next = REQ;
                // A stale response landing with a second redirect still retires the old read.
                DROP:    if (bus.imem_resp) state_next = REQ;
                default: state_next = REQ;
            endcase
        end else begin
            case (state_reg)
                REQ: begin
                    if (bus.imem_resp) begin
                        pc_next = pc_reg + 32'd4;
                        if (slot_free) begin
                            out_valid_next = 1'b1;
                            out_ir_next    = bus.imem_rdata;
                            out_pc_next    = pc_reg;
                        end else begin
                            skid_valid_next = 1'b1;
                            skid_ir_next    = bus.imem_rdata;
                            skid_pc_next    = pc_reg;
                            state_next      = HOLD;
                        end
                    end else if (out_valid_reg && bus.out_ready) begin
                        out_valid_next = 1'b0;
                        out_ir_next    = NOP_INSTR;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_next  = skid_valid_reg;
                        out_ir_next     = skid_ir_reg;
                        out_pc_next     = skid_pc_reg;
                        skid_valid_next = 1'b0;
                        state_next      = REQ;
                    end
                end
                DROP:    if (bus.imem_resp) state_next = REQ;
                default: state_next = REQ;
            endcase
        end
    end

    assign bus.imem_read    = !rst && (state_reg != HOLD);
    assign bus.imem_address = (state_reg == DROP) ? req_addr_reg : (pc_reg & ~32'd3);
    assign bus.out_valid    = out_valid_reg;
    assign bus.out_ir       = out_ir_reg;
    assign bus.out_pc       = out_pc_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a bench-side memory with programmable latency answers
// fetch reads; delivered responses are queued and checked as IF/ID consumes them.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h6000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];
    int          mem_lat = 1;
    int          mem_cnt = 0;
    logic        mem_busy = 1'b0;
    logic        mem_squashed = 1'b0;
    logic [31:0] mem_addr = 32'h0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5A5A_F0F3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive inputs after the edge, run the memory, then score at negedge.
    task automatic step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic [63:0] ent;
        @(posedge clk);
        #1;
        rst                = r;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.out_ready      = rdy;
        #1;
        if (rst) begin
            mem_busy      = 1'b0;
            bus.imem_resp = 1'b0;
        end else begin
            if (bus.imem_resp) begin
                bus.imem_resp = 1'b0;
                mem_busy      = 1'b0;
            end else if (mem_busy) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    bus.imem_resp  = 1'b1;
                    bus.imem_rdata = mem_data(mem_addr);
                end
            end
            if (mem_busy) begin
                chk1("req_hold_read", bus.imem_read, 1'b1);
                chk("req_hold_addr", bus.imem_address, mem_addr);
            end else if (bus.imem_read) begin
                mem_busy     = 1'b1;
                mem_addr     = bus.imem_address;
                mem_cnt      = mem_lat;
                mem_squashed = 1'b0;
            end
        end
        @(negedge clk);
        if (rst) begin
            sb.delete();
        end else if (bus.redirect_valid) begin
            sb.delete();
            if (mem_busy) mem_squashed = 1'b1;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                chk1("sb_has_entry", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    ent = sb.pop_front();
                    chk("sb_out_ir", bus.out_ir, ent[63:32]);
                    chk("sb_out_pc", bus.out_pc, ent[31:0]);
                    $display("xfer pc=%h ir=%h", bus.out_pc, bus.out_ir);
                end
            end
            if (bus.imem_resp && !mem_squashed) sb.push_back({mem_data(mem_addr), mem_addr});
        end
    endtask

    task automatic run(input logic rdy);
        step(1'b0, 1'b0, 32'h0, rdy);
    endtask

    task automatic do_reset(input logic rdy);
        step(1'b1, 1'b0, 32'h0, rdy);
        chk1("rst_read", bus.imem_read, 1'b0);
        step(1'b1, 1'b0, 32'h0, rdy);
        chk1("rst_read2", bus.imem_read, 1'b0);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_ir", bus.out_ir, NOP);
        chk("rst_out_pc", bus.out_pc, 32'h0);
    endtask

    initial begin
        bus.imem_resp      = 1'b0;
        bus.imem_rdata     = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b0;

        // Streaming with a 1-cycle memory and IF/ID always ready
        mem_lat = 1;
        do_reset(1'b1);
        run(1'b1);
        chk1("t1_read0", bus.imem_read, 1'b1);
        chk("t1_addr0", bus.imem_address, RST_PC);
        chk1("t1_valid0", bus.out_valid, 1'b0);
        run(1'b1);
        chk1("t1_valid1", bus.out_valid, 1'b0);
        run(1'b1);
        chk1("t1_valid2", bus.out_valid, 1'b1);
        chk("t1_pc2", bus.out_pc, RST_PC);
        chk("t1_ir2", bus.out_ir, mem_data(RST_PC));
        chk("t1_addr2", bus.imem_address, RST_PC + 32'h4);
        run(1'b1);
        run(1'b1);
        chk("t1_pc4", bus.out_pc, RST_PC + 32'h4);
        chk("t1_addr4", bus.imem_address, RST_PC + 32'h8);
        run(1'b1);
        run(1'b1);
        chk1("t1_valid6", bus.out_valid, 1'b1);
        chk("t1_pc6", bus.out_pc, RST_PC + 32'h8);

        // Backpressure fills output and skid slots
        do_reset(1'b0);
        run(1'b0);
        run(1'b0);
        run(1'b0);
        chk("t2_pc2", bus.out_pc, RST_PC);
        chk("t2_addr2", bus.imem_address, RST_PC + 32'h4);
        run(1'b0);
        run(1'b0);
        chk1("t2_hold_read", bus.imem_read, 1'b0);
        chk("t2_hold_pc", bus.out_pc, RST_PC);
        run(1'b0);
        chk1("t2_hold_read2", bus.imem_read, 1'b0);
        run(1'b1);
        chk1("t2_release_read", bus.imem_read, 1'b0);
        run(1'b1);
        chk1("t2_skid_valid", bus.out_valid, 1'b1);
        chk("t2_skid_pc", bus.out_pc, RST_PC + 32'h4);
        chk1("t2_next_read", bus.imem_read, 1'b1);
        chk("t2_next_addr", bus.imem_address, RST_PC + 32'h8);
        run(1'b1);
        run(1'b1);
        chk("t2_pc8", bus.out_pc, RST_PC + 32'h8);

        // Redirect while the 0x..08 read is outstanding with a 3-cycle memory
        do_reset(1'b1);
        run(1'b1);
        run(1'b1);
        run(1'b1);
        run(1'b1);
        mem_lat = 3;
        run(1'b1);
        chk("t3_addr_req", bus.imem_address, RST_PC + 32'h8);
        step(1'b0, 1'b1, RST_PC + 32'h100, 1'b1);
        chk("t3_addr_redir", bus.imem_address, RST_PC + 32'h8);
        run(1'b1);
        chk1("t3_valid_drop", bus.out_valid, 1'b0);
        chk("t3_addr_drop", bus.imem_address, RST_PC + 32'h8);
        chk1("t3_read_drop", bus.imem_read, 1'b1);
        run(1'b1);
        chk("t3_addr_resp", bus.imem_address, RST_PC + 32'h8);
        mem_lat = 1;
        run(1'b1);
        chk1("t3_read_tgt", bus.imem_read, 1'b1);
        chk("t3_addr_tgt", bus.imem_address, RST_PC + 32'h100);
        chk1("t3_valid_tgt", bus.out_valid, 1'b0);
        run(1'b1);
        run(1'b1);
        chk1("t3_valid_out", bus.out_valid, 1'b1);
        chk("t3_pc_out", bus.out_pc, RST_PC + 32'h100);

        // Redirect coinciding with a response; misaligned target
        do_reset(1'b1);
        run(1'b1);
        step(1'b0, 1'b1, RST_PC + 32'h102, 1'b1);
        run(1'b1);
        chk1("t4_read", bus.imem_read, 1'b1);
        chk("t4_addr", bus.imem_address, RST_PC + 32'h100);
        chk1("t4_valid", bus.out_valid, 1'b0);
        run(1'b1);
        run(1'b1);
        chk("t4_pc", bus.out_pc, RST_PC + 32'h100);
        chk("t4_ir", bus.out_ir, mem_data(RST_PC + 32'h100));

        // Redirect in HOLD with both slots occupied
        do_reset(1'b0);
        run(1'b0);
        run(1'b0);
        run(1'b0);
        run(1'b0);
        run(1'b0);
        chk1("t5_hold_read", bus.imem_read, 1'b0);
        chk1("t5_hold_valid", bus.out_valid, 1'b1);
        step(1'b0, 1'b1, RST_PC + 32'h200, 1'b0);
        run(1'b0);
        chk1("t5_valid", bus.out_valid, 1'b0);
        chk("t5_ir_nop", bus.out_ir, NOP);
        chk1("t5_read", bus.imem_read, 1'b1);
        chk("t5_addr", bus.imem_address, RST_PC + 32'h200);
        run(1'b1);
        run(1'b1);
        chk("t5_pc", bus.out_pc, RST_PC + 32'h200);
        run(1'b1);

        // Reset mid-REQ, then mid-DROP
        do_reset(1'b1);
        mem_lat = 3;
        run(1'b1);
        run(1'b1);
        chk1("t6_req_read", bus.imem_read, 1'b1);
        do_reset(1'b1);
        run(1'b1);
        chk("t6a_addr", bus.imem_address, RST_PC);
        chk1("t6a_read", bus.imem_read, 1'b1);
        step(1'b0, 1'b1, RST_PC + 32'h300, 1'b1);
        run(1'b1);
        chk("t6_drop_addr", bus.imem_address, RST_PC);
        do_reset(1'b1);
        mem_lat = 1;
        run(1'b1);
        chk("t6b_addr", bus.imem_address, RST_PC);
        chk1("t6b_read", bus.imem_read, 1'b1);
        chk1("t6b_valid", bus.out_valid, 1'b0);
        run(1'b1);
        run(1'b1);
        chk("t6b_pc", bus.out_pc, RST_PC);
        run(1'b1);
        run(1'b1);
        run(1'b1);
        run(1'b1);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
